// File: rtl/alu_addsub_seq.sv
// alu_addsub_seq: multi-cycle add/subtract unit.
// Adds CHUNK bits per cycle, least-significant chunk first, and keeps the
// ripple carry in a register between cycles. Reports carry, signed overflow,
// zero and negative flags with the result.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. in_ready is high only in IDLE and out_valid
// only in DONE. rd and the flags stay stable while out_valid=1 and
// out_ready=0.
//
// Optional build macro ALU_SAT_EN: adds the sat input. When sat=1 and the
// signed result overflows, rd is clamped to the most positive or most
// negative value. flag_z and flag_n follow the clamped rd. flag_c and
// flag_v still describe the unclamped sum.
module alu_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
`ifdef ALU_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic [1:0]       o_dbg_state
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cy;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_rd;
  logic             r_flag_c;
  logic             r_flag_v;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_out_valid;
  logic             r_in_ready;
`ifdef ALU_SAT_EN
  logic             r_sat;
`endif

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_msb_cin;
  logic             w_v;
  logic [WIDTH-1:0] w_rd_next;
  logic [WIDTH-1:0] w_rd_final;

  // Chunk adder: current chunk of A and B plus the carry held from the last chunk.
  always_comb begin
    w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_cy};
    // The carry into the top bit is recovered from the top sum bit and its inputs.
    w_msb_cin = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
    w_v       = w_msb_cin ^ w_sum[CHUNK];
  end

  // Result with the current chunk merged in. This is only the full sum on the last chunk.
  always_comb begin
    w_rd_next = r_rd;
    w_rd_next[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
  end

  // Final rd value, clamped on overflow when saturation is requested.
  always_comb begin
    w_rd_final = w_rd_next;
`ifdef ALU_SAT_EN
    // On overflow A and B share a sign, and that sign is the sign of the true result.
    if (r_sat && w_v) begin
      w_rd_final = w_a_chunk[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Control FSM and datapath registers: IDLE accepts, BUSY ripples chunks, DONE holds the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_cy        <= 1'b0;
      r_idx       <= '0;
      r_rd        <= '0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef ALU_SAT_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= rs1;
            // Subtraction is done as rs1 + ~rs2 + 1. The +1 is the initial carry.
            r_b        <= op ? ~rs2 : rs2;
            r_cy       <= op;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
`ifdef ALU_SAT_EN
            r_sat      <= sat;
`endif
          end
        end
        S_BUSY: begin
          r_cy  <= w_sum[CHUNK];
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_rd        <= w_rd_final;
            r_flag_c    <= w_sum[CHUNK];
            r_flag_v    <= w_v;
            r_flag_z    <= (w_rd_final == '0);
            r_flag_n    <= w_rd_final[WIDTH-1];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_rd <= w_rd_next;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign rd          = r_rd;
  assign flag_c      = r_flag_c;
  assign flag_v      = r_flag_v;
  assign flag_z      = r_flag_z;
  assign flag_n      = r_flag_n;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Bench for alu_addsub_seq: a chunked instance (32/8) and a single-cycle
// instance (32/32). Directed steps are followed by random operations.
// Every result is compared against an arithmetic reference model.
module tb_alu_addsub_seq;

  localparam int EW = 36; // {c, v, z, n, rd[31:0]}

  logic        clk;
  logic        reset;
  logic        in_valid0, in_valid1;
  logic        op;
  logic [31:0] rs1, rs2;
  logic        sat;
  logic        out_ready;

  logic        in_ready0, out_valid0, c0, v0, z0, n0;
  logic [31:0] rd0;
  logic [1:0]  dbg0;
  logic        in_ready1, out_valid1, c1, v1, z1, n1;
  logic [31:0] rd1;
  logic [1:0]  dbg1;

  logic          sel;
  logic          m_in_ready, m_out_valid;
  logic [EW-1:0] m_obs;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got;

  alu_addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .op(op), .rs1(rs1), .rs2(rs2),
`ifdef ALU_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid0), .out_ready(out_ready), .rd(rd0),
    .flag_c(c0), .flag_v(v0), .flag_z(z0), .flag_n(n0), .o_dbg_state(dbg0)
  );

  alu_addsub_seq #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .op(op), .rs1(rs1), .rs2(rs2),
`ifdef ALU_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid1), .out_ready(out_ready), .rd(rd1),
    .flag_c(c1), .flag_v(v1), .flag_z(z1), .flag_n(n1), .o_dbg_state(dbg1)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux for the instance under test
  always_comb begin
    m_in_ready  = sel ? in_ready1  : in_ready0;
    m_out_valid = sel ? out_valid1 : out_valid0;
    m_obs       = sel ? {c1, v1, z1, n1, rd1} : {c0, v0, z0, n0, rd0};
  end

  // Reference model: true signed/unsigned arithmetic, then flags from their definitions.
  function automatic logic [EW-1:0] model(input logic o, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    longint      sa, sb, ts;
    logic [32:0] uw;
    logic [31:0] r;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o) begin
      ts = sa - sb;
      uw = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
    end else begin
      ts = sa + sb;
      uw = {1'b0, a} + {1'b0, b};
      c  = uw[32];
    end
    r = uw[31:0];
    v = (ts > 64'sd2147483647) || (ts < -64'sd2147483648);
    if (s && v) r = (ts > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {c, v, (r == 32'd0), r[31], r};
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Driver: one full operation including optional backpressure; returns observed result.
  task automatic run_op(input string tag, input logic u, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input logic s, input int bp,
                        output logic [EW-1:0] obs);
    int            waited;
    logic [EW-1:0] exp;
    sel = u;
    obs = '0;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, EW'(m_in_ready), EW'(1));
    exp = model(o, a, b, s);
    exp_q.push_back(exp);
    op = o; rs1 = a; rs2 = b; sat = s;
    if (u) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    // Inputs changing after acceptance must not matter
    rs1 = $urandom; rs2 = $urandom; op = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
    check({tag, "_in_ready_busy"}, EW'(m_in_ready), EW'(0));
    waited = 0;
    while (!m_out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_latency"}, EW'(waited), EW'(u ? 1 : 4));
    if (!m_out_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    obs = m_obs;
    check({tag, "_result"}, obs, exp_q.pop_front());
    for (int i = 0; i < bp; i++) begin
      if (u) in_valid1 = 1'($urandom_range(0, 1)); else in_valid0 = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, "_hold"}, m_obs, exp);
      check({tag, "_hold_hs"}, EW'({m_out_valid, m_in_ready}), EW'(2'b10));
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release"}, EW'({m_out_valid, m_in_ready}), EW'(2'b01));
  endtask

  initial begin
    reset = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0; op = 1'b0;
    rs1 = '0; rs2 = '0; sat = 1'b0; out_ready = 1'b0; sel = 1'b0;

    // Reset state of both instances
    apply_reset();
    @(negedge clk);
    sel = 1'b0; #1;
    check("reset_obs0", m_obs, '0);
    check("reset_hs0", EW'({m_out_valid, m_in_ready}), EW'(2'b01));
    sel = 1'b1; #1;
    check("reset_obs1", m_obs, '0);
    check("reset_hs1", EW'({m_out_valid, m_in_ready}), EW'(2'b01));

    // Directed arithmetic cases
    run_op("add_71_82", 1'b0, 1'b0, 32'd71, 32'd82, 1'b0, 0, got);
    check("add_71_82_const", got, {4'b0000, 32'd153});
    run_op("sub_71_82", 1'b0, 1'b1, 32'd71, 32'd82, 1'b0, 0, got);
    check("sub_71_82_const", got, {4'b0001, 32'hFFFF_FFF5});
    run_op("sub_71_71", 1'b0, 1'b1, 32'd71, 32'd71, 1'b0, 0, got);
    check("sub_71_71_const", got, {4'b1010, 32'h0000_0000});
    run_op("add_ffff_1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, got);
    check("add_ffff_1_const", got, {4'b1010, 32'h0000_0000});
    run_op("add_7fff_1", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 0, got);
    check("add_7fff_1_const", got, {4'b0101, 32'h8000_0000});
`ifdef ALU_SAT_EN
    run_op("sat_7fff_1", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b1, 0, got);
    check("sat_7fff_1_const", got, {4'b0100, 32'h7FFF_FFFF});
    run_op("sat_8000_sub1", 1'b0, 1'b1, 32'h8000_0000, 32'd1, 1'b1, 0, got);
    check("sat_8000_sub1_const", got, {4'b1101, 32'h8000_0000});
`endif

    // Backpressure: hold out_ready low for 3 cycles with in_valid pulses
    run_op("bp_sub", 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 3, got);

    // Reset in the 2nd BUSY cycle aborts the operation
    sel = 1'b0;
    @(negedge clk);
    op = 1'b0; rs1 = 32'd71; rs2 = 32'd82; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_obs", m_obs, '0);
    check("midreset_ov", EW'(m_out_valid), EW'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_rel_hs", EW'({m_out_valid, m_in_ready}), EW'(2'b01));
    check("midreset_rel_obs", m_obs, '0);
    repeat (6) begin
      @(negedge clk);
      check("midreset_no_ov", EW'(m_out_valid), EW'(0));
    end
    run_op("post_reset", 1'b0, 1'b0, 32'd71, 32'hFFFF_FFAE, 1'b0, 0, got);
    check("post_reset_const", got, {4'b0001, 32'hFFFF_FFF5});

    // Single-cycle instance
    run_op("w32_add", 1'b1, 1'b0, 32'd71, 32'd82, 1'b0, 0, got);
    check("w32_add_const", got, {4'b0000, 32'd153});
    run_op("w32_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'd1, 1'b0, 1, got);

    // Random operations on both instances
    for (int i = 0; i < 40; i++) begin
      logic s_r;
      s_r = 1'b0;
`ifdef ALU_SAT_EN
      s_r = 1'($urandom_range(0, 1));
`endif
      run_op("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             rand_operand(), rand_operand(), s_r, $urandom_range(0, 3), got);
    end

    check("scoreboard_empty", EW'(exp_q.size()), EW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_addsub_seq.md
Name: alu_addsub_seq

Overview:
- Parametrised, multi-cycle add/subtract unit that succeeds the combinational alu_add datapath.
- Processes operands CHUNK bits per cycle, least-significant chunk first, with a rippled carry held in a register between cycles.
- Uses valid/ready handshakes on both input and output, so it drops into a pipelined execute stage.
- Produces the result plus carry, overflow, zero and negative flags.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits processed per cycle. Must divide WIDTH exactly. CHUNK = WIDTH gives single-cycle operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit can accept operands.
- op  input  1  0 = add (rs1+rs2), 1 = subtract (rs1-rs2).
- rs1  input  WIDTH  operand A.
- rs2  input  WIDTH  operand B.
- out_valid  output  1  rd and flags are valid.
- out_ready  input  1  consumer accepts the result.
- rd  output  WIDTH  result.
- flag_c  output  1  carry out; for subtract this is no-borrow (1 when rs1 >= rs2 unsigned).
- flag_v  output  1  signed overflow.
- flag_z  output  1  rd == 0.
- flag_n  output  1  rd[WIDTH-1].

Behaviour:
- Definition: NCH = WIDTH/CHUNK.
- Reset (reset low, asynchronous): state goes to IDLE. rd, all flags, out_valid, the carry register and the chunk index clear to 0. in_ready reads 1 as soon as reset is released.
- FSM state IDLE: in_ready = 1.
  - On an edge with in_valid=1, latch rs1, the operand B (rs2 when op=0, ~rs2 when op=1) and op.
  - The carry register loads op, so subtraction is rs1 + ~rs2 + 1.
  - Chunk index loads 0; go to BUSY.
- FSM state BUSY: in_ready = 0.
  - Each edge adds chunk k of A and B plus the carry register, writes that chunk of rd, and updates the carry register.
  - The chunk index increments on each of these edges.
  - On the edge that processes chunk NCH-1, compute flag_c and flag_v and go to DONE.
- Latency: with the accepting edge at E0, out_valid is first high after edge E0+NCH (4 cycles for the defaults).
- Flag rules:
  - flag_c = final carry out of the MSB.
  - flag_v = carry-in to the MSB XOR carry-out of the MSB.
  - flag_z and flag_n are derived from the final rd.
- FSM state DONE: out_valid = 1, in_ready = 0. rd and flags hold stable while out_ready = 0.
  - On an edge with out_ready=1, go to IDLE and clear out_valid.
  - rd keeps its last value until the next operation overwrites it chunk by chunk.
- Throughput: there is no overlap. A new operation is accepted at the earliest one cycle after the result handshake, giving a maximum rate of one result per NCH+2 cycles.
- In BUSY, rd holds partial results; consumers must read it only while out_valid = 1.
- Inputs are ignored outside IDLE. Changing rs1, rs2 or op after acceptance has no effect.
- Wrap-around: results are modulo 2^WIDTH; carry and overflow are reported only through the flags.
- Reset asserted in BUSY or DONE aborts the operation immediately. The result is lost and no out_valid is produced.

Optional Feature:
- Macro: ALU_SAT_EN.
- When defined:
  - Adds input port sat (1 bit), latched with the operands.
  - If sat=1 and flag_v=1 at completion, rd is forced to 2^(WIDTH-1)-1 when the true result is positive, or to -2^(WIDTH-1) when it is negative.
  - Flags report the unsaturated computation, except flag_z and flag_n, which follow the saturated rd.
- When not defined: no sat port and no clamping logic; rd always wraps.

Test Plan:
- Add, in 1 cycle, out 1 (WIDTH=32, CHUNK=8): rs1=71, rs2=82, op=0 -> out_valid 4 cycles after acceptance; rd=153, c=0, v=0, z=0, n=0.
- Subtract, in 1 cycle, out 1: rs1=71, rs2=82, op=1 -> rd=32'hFFFF_FFF5 (-11), c=0, n=1.
- Then rs1=71, rs2=71, op=1 -> rd=0, z=1, c=1.
- Carry/overflow: 32'hFFFF_FFFF+1 -> rd=0, c=1, z=1, v=0.
- Then 32'h7FFF_FFFF+1 -> rd=32'h8000_0000, v=1, n=1.
- With ALU_SAT_EN, same operands and sat=1 -> rd=32'h7FFF_FFFF, n=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> rd and flags unchanged, in_ready=0, in_valid pulses ignored. Result is released on the out_ready=1 edge; in_ready=1 the next cycle.
- Reset mid-operation, plus CHUNK=WIDTH=32:
  - Assert reset for 1 cycle in the 2nd BUSY cycle -> out_valid=0, rd=0, flags=0, in_ready=1 after release; a following 71+(-82) gives rd=-11.
  - With CHUNK=WIDTH=32, 71+82 -> out_valid after 1 cycle.
